// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state encoding and target helpers
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] END_ADDR = 32'd168;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    // Primary opcode field values decoded in ID
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm16);
        return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] jindex);
        return {pc4[31:28], jindex, 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with hold, flush and load controls
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // hold beats flush beats load; with no control asserted the register keeps its value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (hold) begin
            instr <= instr;
            pc4   <= pc4;
            valid <= valid;
        end else if (flush) begin
            instr <= NOP;
            pc4   <= pc4_d;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, redirect, halt FSM and fetch counter
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] END_ADDR = cpu_pkg::END_ADDR,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_branch_taken,
    input  logic [15:0] id_imm16,
    input  logic        id_jump,
    input  logic [25:0] id_jindex,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         redirect;
    logic         ifid_hold, ifid_flush, ifid_load;
    logic         count_inc;

    assign pc_plus4 = pc + 32'd4;
    // A redirect from ID only counts when ID holds a real instruction; branch wins over jump
    assign redirect = ifid_valid && (id_branch_taken || id_jump);
    assign target   = id_branch_taken ? branch_target(ifid_pc4, id_imm16)
                                      : jump_target(ifid_pc4, id_jindex);
    assign halted   = (state_q == FETCH_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_RUN;
            pc          <= RESET_PC;
            fetch_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            fetch_count <= fetch_count + {31'd0, count_inc};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        count_inc  = 1'b0;
        if (stall) begin
            ifid_hold = 1'b1;
        end else if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
            state_d    = (target >= END_ADDR) ? FETCH_HALT : FETCH_RUN;
        end else if (state_q == FETCH_HALT) begin
            ifid_flush = 1'b1;
        end else if (pc >= END_ADDR) begin
            ifid_flush = 1'b1;
            state_d    = FETCH_HALT;
        end else begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
            count_inc = 1'b1;
        end
    end

    ifid_reg #(
        .NOP (NOP_WORD)
    ) u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .load    (ifid_load),
        .instr_d (imem_instr),
        .pc4_d   (pc_plus4),
        .instr   (ifid_instr),
        .pc4     (ifid_pc4),
        .valid   (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_branch_taken;
    logic [15:0] id_imm16;
    logic        id_jump;
    logic [25:0] id_jindex;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int          tests;
    int          fails;
    logic [63:0] sb_q[$];
    logic        sampled_stall;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .id_branch_taken (id_branch_taken),
        .id_imm16        (id_imm16),
        .id_jump         (id_jump),
        .id_jindex       (id_jindex),
        .imem_instr      (imem_instr),
        .pc              (pc),
        .ifid_instr      (ifid_instr),
        .ifid_pc4        (ifid_pc4),
        .ifid_valid      (ifid_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h2008_0020 : (32'hAC00_0000 | a);
    endfunction

    assign imem_instr = imem_word(pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        sb_q.push_back({imem_word(a), a + 32'd4});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) sampled_stall = stall;

    // Each freshly loaded IF/ID entry must match the oldest expected fetch
    always @(negedge clk) begin
        if (rst_n && ifid_valid && !sampled_stall) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got instr %h pc4 %h expected none", ifid_instr, ifid_pc4);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                if ({ifid_instr, ifid_pc4} !== e) begin
                    fails++;
                    $display("FAIL sb_entry: got %h/%h expected %h/%h",
                             ifid_instr, ifid_pc4, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        sampled_stall = 1'b0;
        rst_n = 1'b0;
        stall = 1'b0;
        id_branch_taken = 1'b0;
        id_imm16 = 16'h0;
        id_jump = 1'b0;
        id_jindex = 26'h0;
        tick();
        tick();
        check("rst_pc", pc, 32'd0);
        check("rst_instr", ifid_instr, 32'd0);
        check("rst_pc4", ifid_pc4, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count", fetch_count, 32'd0);

        rst_n = 1'b1;
        expect_fetch(32'd0);
        tick();
        check("first_pc", pc, 32'd4);
        check("first_count", fetch_count, 32'd1);
        check("first_valid", {31'd0, ifid_valid}, 32'd1);
        expect_fetch(32'd4);
        tick();
        expect_fetch(32'd8);
        tick();
        check("run3_pc", pc, 32'd12);
        check("run3_count", fetch_count, 32'd3);

        stall = 1'b1;
        tick();
        tick();
        check("stall_pc", pc, 32'd12);
        check("stall_count", fetch_count, 32'd3);
        check("stall_instr", ifid_instr, 32'hAC00_0008);
        check("stall_pc4", ifid_pc4, 32'd12);
        stall = 1'b0;
        for (int a = 12; a < 48; a += 4) begin
            expect_fetch(a);
            tick();
        end
        check("pre_br_pc4", ifid_pc4, 32'd48);
        check("pre_br_count", fetch_count, 32'd12);

        stall = 1'b1;
        id_branch_taken = 1'b1;
        id_imm16 = 16'h0012;
        tick();
        check("stall_redirect_pc", pc, 32'd48);
        stall = 1'b0;
        tick();
        check("br_pc", pc, 32'd120);
        check("br_valid", {31'd0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instr, 32'd0);
        check("br_count", fetch_count, 32'd12);
        id_branch_taken = 1'b0;
        expect_fetch(32'd120);
        tick();
        check("post_br_pc", pc, 32'd124);
        check("post_br_count", fetch_count, 32'd13);

        id_jump = 1'b1;
        id_jindex = 26'hF;
        tick();
        check("j60_pc", pc, 32'd60);
        id_jump = 1'b0;
        expect_fetch(32'd60);
        tick();
        check("at64_pc4", ifid_pc4, 32'd64);
        id_branch_taken = 1'b1;
        id_jump = 1'b1;
        id_imm16 = 16'hFFFF;
        id_jindex = 26'h17;
        tick();
        check("br_wins_pc", pc, 32'd60);
        check("br_wins_count", fetch_count, 32'd14);
        id_branch_taken = 1'b0;
        id_jump = 1'b0;
        expect_fetch(32'd60);
        tick();
        id_jump = 1'b1;
        tick();
        check("j92_pc", pc, 32'd92);
        check("j92_count", fetch_count, 32'd15);
        id_jump = 1'b0;
        expect_fetch(32'd92);
        tick();
        expect_fetch(32'd96);
        tick();
        check("pre_rst_pc", pc, 32'd100);

        #2 rst_n = 1'b0;
        #1;
        check("async_pc", pc, 32'd0);
        check("async_valid", {31'd0, ifid_valid}, 32'd0);
        check("async_count", fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 168; a += 4) begin
            expect_fetch(a);
            tick();
        end
        check("end_pc", pc, 32'd168);
        check("end_count", fetch_count, 32'd42);
        check("end_halted0", {31'd0, halted}, 32'd0);
        tick();
        check("end_halted1", {31'd0, halted}, 32'd1);
        check("end_valid", {31'd0, ifid_valid}, 32'd0);
        check("end_pc_hold", pc, 32'd168);
        check("end_count_hold", fetch_count, 32'd42);
        id_jump = 1'b1;
        id_jindex = 26'h1;
        tick();
        check("halt_ignore_j_pc", pc, 32'd168);
        check("halt_ignore_j_st", {31'd0, halted}, 32'd1);
        id_jump = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_fetch(32'd0);
        tick();
        id_jump = 1'b1;
        id_jindex = 26'h3F;
        tick();
        check("j252_pc", pc, 32'd252);
        check("j252_halted", {31'd0, halted}, 32'd1);
        id_jump = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_pc", pc, 32'd252);
            check("halt_count", fetch_count, 32'd1);
            check("halt_state", {31'd0, halted}, 32'd1);
        end
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
